// File: rtl/game_pkg.sv
// Shared types and constants for the stickman runner game-status logic.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HIT,
      OVER
   } game_state_t;

   localparam logic [7:0]  KEY_ENTER = 8'h28;
   localparam logic [7:0]  KEY_SPACE = 8'h2C;

   // Largest value a 4-digit BCD word can hold; the score saturates here.
   localparam logic [15:0] BCD_MAX   = 16'h9999;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, saturating at 9999.
module bcd_counter4
   import game_pkg::*;
(
   input  logic        Clk,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] q
);

   logic [15:0] q_nxt;
   logic        carry;

   // Ripple a +1 through the digits; a 9 wraps to 0 and carries onward.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      q_nxt = q;
      carry = 1'b1;
      if (q != BCD_MAX) begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (q[i*4 +: 4] == 4'd9) begin
                  q_nxt[i*4 +: 4] = 4'd0;
               end else begin
                  q_nxt[i*4 +: 4] = q[i*4 +: 4] + 4'd1;
                  carry           = 1'b0;
               end
            end
         end
      end
   end

   // Count register; clear dominates increment.
   always_ff @(posedge Clk) begin
      if (clr) begin
         q <= '0;
      end else if (inc) begin
         q <= q_nxt;
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// Game-status controller: frame tick and start-key edge detection,
// collision latch, IDLE/RUN/HIT/OVER sequencing, score and high score.
module game_ctrl
   import game_pkg::*;
#(
   parameter logic [7:0] START_KEY  = KEY_ENTER,
   parameter int         SCORE_DIV  = 6,
   parameter int         HIT_FRAMES = 30
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [7:0]  keycode,
   input  logic        is_stickman,
   input  logic        is_obstacle,
   output logic        playing,
   output logic        freeze,
   output logic        game_over,
   output logic [15:0] score,
   output logic [15:0] high_score
);

   // A divider or frame count of 1 would give a zero-width counter, so keep one bit.
   localparam int DIV_W = (SCORE_DIV  > 1) ? $clog2(SCORE_DIV)  : 1;
   localparam int HIT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCORE_DIV - 1);
   localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(HIT_FRAMES - 1);

   game_state_t      state;
   game_state_t      state_nxt;

   logic             frame_d;
   logic             tick;
   logic [7:0]       key_d;
   logic             start;
   logic             overlap;
   logic             hit_flag;
   logic             hit_now;
   logic             state_change;
   logic             run_entry;
   logic [DIV_W-1:0] div_cnt;
   logic [HIT_W-1:0] hit_cnt;
   logic             score_clr;
   logic             score_inc;

   // Sample the frame clock and keycode to find their rising/new-press edges.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
         frame_d <= 1'b0;
         tick    <= 1'b0;
         key_d   <= 8'h00;
      end else begin
         frame_d <= frame_clk;
         tick    <= frame_clk & ~frame_d;
         key_d   <= keycode;
      end
   end

   // Holding the key keeps key_d equal to it, so only the first cycle starts a game.
   assign start   = (keycode == START_KEY) && (key_d != START_KEY);
   assign overlap = is_stickman & is_obstacle;
   assign hit_now = hit_flag | overlap;

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decision; start only matters when no game is in progress.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)                         state_nxt = RUN;
         RUN:     if (tick && hit_now)               state_nxt = HIT;
         HIT:     if (tick && (hit_cnt == HIT_LAST)) state_nxt = OVER;
         OVER:    if (start)                         state_nxt = RUN;
         default:                                    state_nxt = IDLE;
      endcase
   end

   assign state_change = (state_nxt != state);
   assign run_entry    = (state_nxt == RUN) && (state != RUN);

   // Output decode straight from the state register.
   always_comb begin
      playing   = 1'b0;
      freeze    = 1'b0;
      game_over = 1'b0;
      case (state)
         RUN:     playing = 1'b1;
         HIT: begin
            playing = 1'b1;
            freeze  = 1'b1;
         end
         OVER:    game_over = 1'b1;
         default: ;
      endcase
   end

   // Remember any overlap seen during the current frame; each tick starts a new frame.
   always_ff @(posedge Clk) begin
      if (Reset || (state != RUN) || tick) begin
         hit_flag <= 1'b0;
      end else if (overlap) begin
         hit_flag <= 1'b1;
      end
   end

   // Frame counters restart on every state entry and advance only on ticks.
   always_ff @(posedge Clk) begin
      if (Reset || state_change) begin
         div_cnt <= '0;
         hit_cnt <= '0;
      end else if (tick) begin
         if (state == RUN) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
         end
         if (state == HIT) begin
            hit_cnt <= hit_cnt + HIT_W'(1);
         end
      end
   end

   // A point is earned on the last frame of each divider period, unless that frame is a hit.
   assign score_clr = Reset | run_entry;
   assign score_inc = (state == RUN) && tick && !hit_now && (div_cnt == DIV_LAST);

   bcd_counter4 u_score (
      .Clk (Clk),
      .clr (score_clr),
      .inc (score_inc),
      .q   (score)
   );

   // Capture a new best score as the freeze animation finishes; BCD words compare as binary.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         high_score <= 16'h0000;
      end else if ((state == HIT) && (state_nxt == OVER) && (score > high_score)) begin
         high_score <= score;
      end
   end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: the driver updates a decimal-score game model
// and queues the expected outputs; a monitor compares them against the DUT.
module tb_game_ctrl;
   import game_pkg::*;

   localparam int SCORE_DIV  = 6;
   localparam int HIT_FRAMES = 30;

   logic        Clk         = 1'b0;
   logic        Reset       = 1'b1;
   logic        frame_clk   = 1'b0;
   logic [7:0]  keycode     = 8'h00;
   logic        is_stickman = 1'b0;
   logic        is_obstacle = 1'b0;
   logic        playing;
   logic        freeze;
   logic        game_over;
   logic [15:0] score;
   logic [15:0] high_score;

   game_ctrl #(
      .START_KEY  (KEY_ENTER),
      .SCORE_DIV  (SCORE_DIV),
      .HIT_FRAMES (HIT_FRAMES)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_clk   (frame_clk),
      .keycode     (keycode),
      .is_stickman (is_stickman),
      .is_obstacle (is_obstacle),
      .playing     (playing),
      .freeze      (freeze),
      .game_over   (game_over),
      .score       (score),
      .high_score  (high_score)
   );

   always #10 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_RUN, M_HIT, M_OVER} mphase_t;

   mphase_t m_phase;
   int      m_score;      // decimal points
   int      m_high;
   int      m_frames;     // clean frames since the last point
   int      m_hit_ticks;  // frames spent frozen
   bit      m_pend;       // overlap seen in the current running frame

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic void model_reset();
      m_phase     = M_IDLE;
      m_score     = 0;
      m_high      = 0;
      m_frames    = 0;
      m_hit_ticks = 0;
      m_pend      = 1'b0;
   endfunction

   // One decision cycle: optional frame tick, optional overlap, optional start press.
   function automatic void model_event(input bit t, input bit ov, input bit st);
      if (st && (m_phase == M_IDLE || m_phase == M_OVER)) begin
         m_phase  = M_RUN;
         m_score  = 0;
         m_frames = 0;
         m_pend   = 1'b0;
      end else if (t) begin
         if (m_phase == M_RUN) begin
            if (m_pend || ov) begin
               m_phase     = M_HIT;
               m_hit_ticks = 0;
            end else begin
               m_frames++;
               if (m_frames == SCORE_DIV) begin
                  m_frames = 0;
                  if (m_score < 9999) m_score++;
               end
            end
         end else if (m_phase == M_HIT) begin
            m_hit_ticks++;
            if (m_hit_ticks == HIT_FRAMES) begin
               m_phase = M_OVER;
               if (m_score > m_high) m_high = m_score;
            end
         end
         m_pend = 1'b0;
      end else if (ov && m_phase == M_RUN) begin
         m_pend = 1'b1;
      end
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      int          due;
      string       name;
      bit          playing;
      bit          freeze;
      bit          over;
      bit          hflag;
      logic [15:0] score;
      logic [15:0] high;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void push_exp(input string name);
      exp_t e;
      e.due     = cyc;
      e.name    = name;
      e.playing = (m_phase == M_RUN) || (m_phase == M_HIT);
      e.freeze  = (m_phase == M_HIT);
      e.over    = (m_phase == M_OVER);
      e.hflag   = m_pend;
      e.score   = to_bcd(m_score);
      e.high    = to_bcd(m_high);
      sb.push_back(e);
   endfunction

   always @(negedge Clk) begin : monitor
      exp_t e;
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         checks++;
         if (playing !== e.playing || freeze !== e.freeze || game_over !== e.over ||
             score !== e.score || high_score !== e.high || dut.hit_flag !== e.hflag) begin
            errors++;
            $display("FAIL %s @cyc %0d: got playing=%0b freeze=%0b game_over=%0b score=%h high=%h hit_flag=%0b; expected playing=%0b freeze=%0b game_over=%0b score=%h high=%h hit_flag=%0b",
                     e.name, cyc, playing, freeze, game_over, score, high_score, dut.hit_flag,
                     e.playing, e.freeze, e.over, e.score, e.high, e.hflag);
         end
      end
   end

   // ---------------- driver ----------------
   // Optional mid-frame overlap cycle, optional frame pulse, then the decision
   // cycle (tick/start/overlap), then one quiet cycle so key_d returns to 0.
   task automatic step(input bit do_tick, input bit ov_mid, input bit ov_tick,
                       input bit do_start, input string name);
      if (ov_mid) begin
         is_stickman = 1'b1;
         is_obstacle = 1'b1;
         @(negedge Clk);
         is_stickman = 1'b0;
         is_obstacle = 1'b0;
         model_event(1'b0, 1'b1, 1'b0);
      end
      if (do_tick) begin
         frame_clk = 1'b1;
         @(negedge Clk);
         frame_clk = 1'b0;
      end
      if (do_start)                         keycode = KEY_ENTER;
      else if ($urandom_range(0, 3) == 0)   keycode = KEY_SPACE;
      if (ov_tick) begin
         is_stickman = 1'b1;
         is_obstacle = 1'b1;
      end
      @(negedge Clk);
      keycode     = 8'h00;
      is_stickman = 1'b0;
      is_obstacle = 1'b0;
      model_event(do_tick, ov_tick, do_start);
      push_exp(name);
      @(negedge Clk);
   endtask

   task automatic run_ticks(input int n, input string name);
      for (int i = 1; i <= n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("%s_%0d", name, i));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      // Reset state.
      @(negedge Clk);
      model_reset();
      push_exp("reset");
      Reset = 1'b0;
      @(negedge Clk);

      // Overlap while idle changes nothing.
      step(1'b0, 1'b1, 1'b0, 1'b0, "idle_overlap");
      step(1'b1, 1'b1, 1'b1, 1'b0, "idle_overlap_tick");

      // Enter held for three cycles: one start, playing one cycle later.
      keycode = KEY_ENTER;
      push_exp("start_cycle");
      @(negedge Clk);
      model_event(1'b0, 1'b0, 1'b1);
      push_exp("start_latency");
      @(negedge Clk);
      push_exp("enter_held");
      @(negedge Clk);
      keycode = 8'h00;
      @(negedge Clk);

      // 60 clean frames: ten points, including the 9 -> 10 carry.
      run_ticks(60, "run");

      // Mid-frame overlap, then the hit on the next tick.
      step(1'b0, 1'b1, 1'b0, 1'b0, "mid_frame_overlap");
      step(1'b1, 1'b0, 1'b0, 1'b0, "hit_tick");
      run_ticks(HIT_FRAMES, "freeze");

      // Overlap in OVER is ignored.
      step(1'b0, 1'b1, 1'b1, 1'b0, "over_overlap");
      step(1'b1, 1'b1, 1'b1, 1'b0, "over_overlap_tick");

      // Second, shorter game started on a tick; high score must survive.
      step(1'b1, 1'b0, 1'b0, 1'b1, "restart_on_tick");
      run_ticks(12, "game2");
      step(1'b1, 1'b0, 1'b1, 1'b0, "game2_hit_on_tick");
      run_ticks(HIT_FRAMES, "game2_freeze");

      // Randomized play.
      for (int i = 0; i < 250; i++) begin
         step($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < 5,  $urandom_range(0, 99) < 10,
              $sformatf("rand_%0d", i));
      end

      // Saturation at 9999.
      while (m_phase == M_HIT) step(1'b1, 1'b0, 1'b0, 1'b0, "drain_hit");
      if (m_phase != M_RUN) step(1'b0, 1'b0, 1'b0, 1'b1, "sat_start");
      force dut.u_score.q = 16'h9999;
      @(negedge Clk);
      release dut.u_score.q;
      m_score = 9999;
      push_exp("sat_forced");
      @(negedge Clk);
      run_ticks(12, "sat");
      step(1'b1, 1'b0, 1'b1, 1'b0, "sat_hit");
      run_ticks(HIT_FRAMES, "sat_freeze");

      // Reset in the middle of HIT, coincident with a tick.
      step(1'b0, 1'b0, 1'b0, 1'b1, "pre_reset_start");
      step(1'b1, 1'b0, 1'b1, 1'b0, "pre_reset_hit");
      run_ticks(5, "pre_reset_freeze");
      frame_clk = 1'b1;
      @(negedge Clk);
      frame_clk = 1'b0;
      Reset     = 1'b1;
      @(negedge Clk);
      model_reset();
      push_exp("reset_mid_hit");
      Reset = 1'b0;
      @(negedge Clk);
      step(1'b1, 1'b0, 1'b0, 1'b0, "post_reset_idle");

      repeat (3) @(negedge Clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries pending, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-status controller for the stickman runner. It sits directly downstream of the stickman and obstacle sprite stages: it consumes their per-pixel `is_stickman` / `is_obstacle` flags to detect collisions and sequences the game through idle, run, hit and game-over. It produces the `playing` level that the stickman stage uses as its run/reset qualifier. It also maintains the running score and the session high score as BCD for the HUD renderer.

## Interface
Parameters:
- `START_KEY`, 8'h28: keycode (Enter) that starts or restarts a game.
- `SCORE_DIV`, 6: frames per score point.
- `HIT_FRAMES`, 30: frames the freeze animation lasts before game over.

Ports:
- `Clk`, in, 1: 50 MHz clock.
- `Reset`, in, 1: synchronous, active-high reset.
- `frame_clk`, in, 1: VGA vsync-derived frame clock (~60 Hz), asynchronous-looking level.
- `keycode`, in, 8: last received key, 8'h00 when none.
- `is_stickman`, in, 1: current pixel belongs to the stickman sprite.
- `is_obstacle`, in, 1: current pixel belongs to any obstacle.
- `playing`, out, 1: 1 in RUN and HIT.
- `freeze`, out, 1: 1 in HIT only; obstacle scroller and background halt motion.
- `game_over`, out, 1: 1 in OVER only.
- `score`, out, 16: 4-digit BCD, digit 3 in [15:12].
- `high_score`, out, 16: 4-digit BCD.

## Operation
- Frame tick:
  - `frame_d <= frame_clk`.
  - `tick <= frame_clk & ~frame_d`.
  - `tick` is a registered one-cycle pulse per frame.
- Start edge:
  - `key_d <= keycode`.
  - `start = (keycode == START_KEY) && (key_d != START_KEY)`.
  - Holding the key generates only one start.
- Collision:
  - `hit_now = hit_flag | (is_stickman & is_obstacle)`.
  - In RUN, `hit_flag` is set on any cycle where both flags are high.
  - `hit_flag` clears on every `tick`.
  - `hit_flag` clears on entry to RUN.
  - Outside RUN, `hit_flag` is held at 0.
- States:
  - IDLE, after reset: `start` goes to RUN.
  - RUN:
    - On `tick` with `hit_now`: go to HIT and clear `hit_cnt`. The score is not incremented on that tick.
    - On `tick` without a hit: advance `div_cnt`. At `SCORE_DIV-1`, wrap `div_cnt` to 0 and increment `score`.
  - HIT:
    - On each `tick`, `hit_cnt++`.
    - When `hit_cnt == HIT_FRAMES-1` on a `tick`: go to OVER, and load `high_score <= score` if `score > high_score`.
    - `start` is ignored in HIT.
  - OVER: `start` goes to RUN.
- RUN entry, from IDLE or OVER, all in the same cycle:
  - `score <= 0`
  - `div_cnt <= 0`
  - `hit_flag <= 0`
- Score arithmetic:
  - BCD ripple increment; a digit at 9 wraps to 0 and carries into the next digit.
  - 9999 saturates: it stays 9999 and `div_cnt` keeps cycling.
  - A binary compare of the BCD words is a valid magnitude compare.
- Width rules:
  - `div_cnt` is `$clog2(SCORE_DIV)` bits wide.
  - `hit_cnt` is `$clog2(HIT_FRAMES)` bits wide.
  - Both are cleared on every state entry.
- Output persistence:
  - `score` is retained through HIT and OVER for display.
  - `high_score` is cleared only by `Reset`.

## Timing
- Reset values:
  - State: IDLE.
  - `playing`, `freeze`, `game_over`: 0.
  - `score`, `high_score`: 16'h0000.
  - `hit_flag`, `tick`, `frame_d`, `key_d`, counters: 0.
- Reset has priority over every event, including mid-HIT and mid-tick. After reset, the block is in IDLE on the next cycle.
- Outputs are registered and decoded from the state register. `playing` rises the cycle after the `start` cycle.
- `tick` latency: high during the cycle after the Clk edge that first samples `frame_clk` high, combined with `frame_d` low.
- Collision on the tick cycle itself: the overlap is counted in the current frame's decision via `hit_now`.
- `start` coincident with `tick`:
  - In IDLE or OVER, the state change wins and the tick is consumed with no effect.
  - In RUN, `start` is ignored.
- The `high_score` update is in the same cycle as the HIT to OVER transition. `game_over` is visible one cycle later, together with the new `high_score`.

## Structure
- Package `game_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, HIT, OVER} game_state_t`.
  - `KEY_ENTER = 8'h28`.
  - `KEY_SPACE = 8'h2C`.
- Sub-module `bcd_counter4`:
  - Interface: `Clk`, `clr`, `inc`, 16-bit `q`.
  - One-cycle increment, saturating at 9999.
  - Instantiated once for `score`.
- FSM, tick/start detection, collision latch and high-score register live in `game_ctrl`.

## Test plan
- Reset then Enter pulse (8'h28 for 3 cycles, then 8'h00):
  - Exactly one RUN entry.
  - `playing` = 1 the cycle after the first `start` cycle.
  - `score` = 0.
- 60 ticks in RUN, no overlap, `SCORE_DIV` = 6: `score` = 16'h0010. The 9→10 carry is checked at tick 60.
- Single-cycle overlap (`is_stickman` = `is_obstacle` = 1) mid-frame:
  - HIT on the next `tick`, with `freeze` = 1.
  - `score` unchanged on that tick.
  - After 30 more ticks: OVER, `playing` = 0, `game_over` = 1, `high_score` = `score`.
- Overlap in IDLE or OVER: no state change and `hit_flag` stays 0.
- Force `score` to 16'h9999, run 12 ticks: `score` stays 9999.
- Second game scoring less than the first: `high_score` is retained.
- `Reset` asserted mid-HIT: all outputs return to reset values the next cycle, including `high_score` = 0.
